f1_reaction_timer: RTL and testbench
====================================

F1_REACTION_TIMER -- requirements
Module: f1_reaction_timer

Interface
REQ-001 Parameter NUM_LIGHTS, default 10: number of start lights, range 2..16.
REQ-002 Parameter STEP_TICKS, default 500: ticks between successive lights coming on, at least 1.
REQ-003 Parameter LFSR_W, default 7: random-delay LFSR width, range 4..8.
REQ-004 Parameter MIN_DELAY, default 200: ticks of fixed hold after all lights are on.
REQ-005 Parameter DELAY_UNIT, default 16: ticks per LFSR count added to the hold.
REQ-006 Parameter TIME_W, default 14: reaction-time width in ms.
REQ-007 One clock; reset is asynchronous and active-high.
REQ-008 clk  in  1  system clock; all logic is on its rising edge.
REQ-009 rst  in  1  asynchronous active-high reset.
REQ-010 tick  in  1  one-cycle timebase enable pulse (1 ms in product).
REQ-011 trigger  in  1  start request, synchronous level.
REQ-012 react  in  1  driver button, synchronous level, active-high.
REQ-013 lights  out  NUM_LIGHTS  light drive; bit 0 lights first.
REQ-014 time_ms  out  TIME_W  last measured reaction time in ticks.
REQ-015 valid  out  1  one-cycle pulse when time_ms updates.
REQ-016 jump_start  out  1  held high after a react before lights-out.
REQ-017 busy  out  1  high in LIGHTS, HOLD and TIMING.

Function
REQ-018 States: IDLE, LIGHTS, HOLD, TIMING, DONE and FAULT; all outputs are registered.
REQ-019 In IDLE, DONE or FAULT, trigger=1 enters LIGHTS next cycle with lights=0, the step counter at 0, and jump_start cleared; trigger is ignored while busy=1.
REQ-020 In LIGHTS, the step counter advances only on tick; on the tick where it equals STEP_TICKS-1, it resets and lights shifts left with a 1 filled into bit 0.
REQ-021 When lights becomes all ones (the same edge as the last shift), the block enters HOLD and loads the hold counter with MIN_DELAY + snap*DELAY_UNIT; snap is the LFSR value on that cycle.
REQ-022 In HOLD, the counter decrements on tick; on the tick where it equals 1, lights becomes all zero, the block enters TIMING and the time counter is cleared.
REQ-023 In TIMING, the time counter increments on tick and saturates at 2^TIME_W-1.
REQ-024 In TIMING, react=1 latches time_ms with the current count, excluding any tick in the same cycle; valid pulses for 1 cycle and the block enters DONE.
REQ-025 react=1 in LIGHTS or HOLD enters FAULT: lights all zero, jump_start=1, and time_ms and valid are unchanged.
REQ-026 react on the same cycle as the HOLD-ending tick is a jump start.
REQ-027 react in IDLE, DONE or FAULT is ignored.
REQ-028 time_ms holds its value until the next valid pulse; it is not cleared on trigger.
REQ-029 The LFSR is maximal-length Fibonacci, advances every clk cycle regardless of tick, seeds to 1 on reset, and never reaches zero.
REQ-030 The hold counter width is sized for MIN_DELAY + (2^LFSR_W-1)*DELAY_UNIT with no overflow.

Reset
REQ-031 rst forces state IDLE, lights=0, time_ms=0, valid=0, jump_start=0, busy=0, all counters to 0 and LFSR to 1, asynchronously, in any state.
REQ-032 After rst deasserts, the block waits for trigger; a sequence interrupted by reset never resumes.

Structure
REQ-033 Package f1_pkg holds the state enum and the LFSR tap-mask constant table for widths 4..8.
REQ-034 The LFSR is a sub-module lfsr_n, parametrised by width, with ports clk, rst and value.
REQ-035 Counter widths are derived with $clog2 from parameters; no literal widths.

Verification (NUM_LIGHTS=4, STEP_TICKS=2, LFSR_W=4, MIN_DELAY=3, DELAY_UNIT=1, TIME_W=8, tick=1 unless noted)
REQ-036 The bench shall cover a normal run: trigger pulse, then react 5 cycles after lights=0 -> lights 0001,0011,0111,1111 at 2-cycle spacing, hold = 3+snap cycles, time_ms=5, valid for 1 cycle.
REQ-037 The bench shall cover a jump start: react high while lights=0011 -> lights=0000 and jump_start=1 next cycle, valid never pulses, and trigger clears jump_start.
REQ-038 The bench shall cover saturation: no react for 300 ticks in TIMING, then react -> time_ms=255.
REQ-039 The bench shall cover tick gating: tick every 4th cycle -> all step, hold and timing intervals are scaled by 4, and the LFSR still steps every cycle.
REQ-040 The bench shall cover reset mid-HOLD: rst asserted -> all outputs are at reset values before the next edge, and no activity occurs until trigger.
REQ-041 The bench shall cover the boundary react: react on the HOLD-ending tick -> FAULT; trigger during TIMING -> ignored, and time is measured normally.

Source files
------------

// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light reaction timer.
package f1_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LIGHTS,
    ST_HOLD,
    ST_TIMING,
    ST_DONE,
    ST_FAULT
  } state_t;

  // Maximal-length Fibonacci feedback taps, bit i set means register bit i feeds the XOR
  localparam logic [7:0] LFSR_TAPS [4:8] = '{8'h0C, 8'h14, 8'h30, 8'h60, 8'hB8};

endpackage

// File: rtl/f1_reaction_timer_lfsr.sv
// Free-running maximal-length Fibonacci LFSR, seeded to 1 and stepped every clock.
module lfsr_n
  import f1_pkg::*;
#(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] value
);

  localparam logic [7:0]   TAPS_FULL = LFSR_TAPS[W];
  localparam logic [W-1:0] TAPS      = TAPS_FULL[W-1:0];

  logic [W-1:0] r_state;
  logic         w_fb;

  assign w_fb = ^(r_state & TAPS);

  // A nonzero seed on a maximal-length polynomial never reaches the all-zero lockup state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= W'(1);
    end else begin
      r_state <= {r_state[W-2:0], w_fb};
    end
  end

  assign value = r_state;

endmodule

// File: rtl/f1_reaction_timer.sv
// F1 start-light sequencer: lights build up, random hold, lights out, then times the driver's reaction.
module f1_reaction_timer
  import f1_pkg::*;
#(
  parameter int unsigned NUM_LIGHTS = 10,
  parameter int unsigned STEP_TICKS = 500,
  parameter int unsigned LFSR_W     = 7,
  parameter int unsigned MIN_DELAY  = 200,
  parameter int unsigned DELAY_UNIT = 16,
  parameter int unsigned TIME_W     = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  trigger,
  input  logic                  react,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic [TIME_W-1:0]     time_ms,
  output logic                  valid,
  output logic                  jump_start,
  output logic                  busy
);

  localparam int unsigned STEP_W   = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int unsigned HOLD_MAX = MIN_DELAY + ((2 ** LFSR_W) - 1) * DELAY_UNIT;
  localparam int unsigned HOLD_W   = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS - 1);

  state_t                  r_state,   w_state;
  logic [NUM_LIGHTS-1:0]   r_lights,  w_lights;
  logic [STEP_W-1:0]       r_step,    w_step;
  logic [HOLD_W-1:0]       r_hold,    w_hold;
  logic [TIME_W-1:0]       r_time,    w_time;
  logic [TIME_W-1:0]       r_time_ms, w_time_ms;
  logic                    r_valid,   w_valid;
  logic                    r_jump,    w_jump;
  logic                    r_busy,    w_busy;

  logic [LFSR_W-1:0]       w_snap;
  logic [NUM_LIGHTS-1:0]   w_shift;
  logic [HOLD_W-1:0]       w_hold_load;

  lfsr_n #(
    .W (LFSR_W)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (w_snap)
  );

  assign w_shift     = {r_lights[NUM_LIGHTS-2:0], 1'b1};
  assign w_hold_load = HOLD_W'(MIN_DELAY) + HOLD_W'(w_snap) * HOLD_W'(DELAY_UNIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_lights  <= '0;
      r_step    <= '0;
      r_hold    <= '0;
      r_time    <= '0;
      r_time_ms <= '0;
      r_valid   <= 1'b0;
      r_jump    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_lights  <= w_lights;
      r_step    <= w_step;
      r_hold    <= w_hold;
      r_time    <= w_time;
      r_time_ms <= w_time_ms;
      r_valid   <= w_valid;
      r_jump    <= w_jump;
      r_busy    <= w_busy;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_lights  = r_lights;
    w_step    = r_step;
    w_hold    = r_hold;
    w_time    = r_time;
    w_time_ms = r_time_ms;
    w_valid   = 1'b0;
    w_jump    = r_jump;

    case (r_state)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (trigger) begin
          w_state  = ST_LIGHTS;
          w_lights = '0;
          w_step   = '0;
          w_jump   = 1'b0;
        end
      end

      ST_LIGHTS: begin
        if (react) begin
          w_state  = ST_FAULT;
          w_lights = '0;
          w_jump   = 1'b1;
        end else if (tick) begin
          if (r_step == STEP_LAST) begin
            w_step   = '0;
            w_lights = w_shift;
            if (&w_shift) begin
              w_state = ST_HOLD;
              w_hold  = w_hold_load;
            end
          end else begin
            w_step = r_step + STEP_W'(1);
          end
        end
      end

      // React outranks the final hold tick, so a simultaneous press is a jump start
      ST_HOLD: begin
        if (react) begin
          w_state  = ST_FAULT;
          w_lights = '0;
          w_jump   = 1'b1;
        end else if (tick) begin
          if (r_hold <= HOLD_W'(1)) begin
            w_state  = ST_TIMING;
            w_lights = '0;
            w_hold   = '0;
            w_time   = '0;
          end else begin
            w_hold = r_hold - HOLD_W'(1);
          end
        end
      end

      ST_TIMING: begin
        if (react) begin
          w_state   = ST_DONE;
          w_time_ms = r_time;
          w_valid   = 1'b1;
        end else if (tick && (r_time != {TIME_W{1'b1}})) begin
          w_time = r_time + TIME_W'(1);
        end
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase

    w_busy = (w_state == ST_LIGHTS) || (w_state == ST_HOLD) || (w_state == ST_TIMING);
  end

  assign lights     = r_lights;
  assign time_ms    = r_time_ms;
  assign valid      = r_valid;
  assign jump_start = r_jump;
  assign busy       = r_busy;

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Directed bench for f1_reaction_timer with small parameters and hand-derived expectations.
module tb_f1_reaction_timer;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       tick    = 1'b1;
  logic       trigger = 1'b0;
  logic       react   = 1'b0;
  logic [3:0] lights;
  logic [7:0] time_ms;
  logic       valid;
  logic       jump_start;
  logic       busy;

  int          n_total   = 0;
  int          n_bad     = 0;
  bit          gate_mode = 1'b0;
  int unsigned cyc       = 0;

  logic [3:0] m_lfsr;
  logic [3:0] m_prev;

  always #5 clk = ~clk;

  f1_reaction_timer #(
    .NUM_LIGHTS (4),
    .STEP_TICKS (2),
    .LFSR_W     (4),
    .MIN_DELAY  (3),
    .DELAY_UNIT (1),
    .TIME_W     (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .trigger    (trigger),
    .react      (react),
    .lights     (lights),
    .time_ms    (time_ms),
    .valid      (valid),
    .jump_start (jump_start),
    .busy       (busy)
  );

  // Reference x^4+x^3+1 sequence; m_prev is the value present during the cycle just finished
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr <= 4'd1;
      m_prev <= 4'd1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      tick = gate_mode ? ((cyc % 4) == 0) : 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_lights(input string tag, input logic [3:0] want, input int max, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while ((lights !== want) && (n < max));
    if (lights !== want) check_eq({tag, "_timeout"}, 32'(lights), 32'(want));
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
  endtask

  // Walks the light build-up after a trigger edge; returns the LFSR value the hold was loaded from
  task automatic climb(input string tag, input int scale, output int snap);
    int n;
    wait_lights({tag, "_l1"}, 4'b0001, 40 * scale, n);
    if (scale == 1) check_eq({tag, "_l1_gap"}, n, 2);
    wait_lights({tag, "_l2"}, 4'b0011, 40 * scale, n);
    check_eq({tag, "_l2_gap"}, n, 2 * scale);
    wait_lights({tag, "_l3"}, 4'b0111, 40 * scale, n);
    check_eq({tag, "_l3_gap"}, n, 2 * scale);
    wait_lights({tag, "_l4"}, 4'b1111, 40 * scale, n);
    check_eq({tag, "_l4_gap"}, n, 2 * scale);
    snap = int'(m_prev);
    check_eq({tag, "_lfsr"}, 32'(dut.w_snap), 32'(m_lfsr));
  endtask

  task automatic run_to_timing(input string tag, input int scale, output int snap);
    int n;
    pulse_trigger();
    check_eq({tag, "_busy_go"}, busy, 1);
    check_eq({tag, "_jump_go"}, jump_start, 0);
    climb(tag, scale, snap);
    wait_lights({tag, "_out"}, 4'b0000, 40 * scale, n);
    check_eq({tag, "_hold"}, n, scale * (3 + snap));
    check_eq({tag, "_busy_tm"}, busy, 1);
  endtask

  initial begin
    int  snap;
    bit  seen;

    step(2);
    check_eq("rst_lights", lights, 0);
    check_eq("rst_time", time_ms, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_jump", jump_start, 0);
    check_eq("rst_busy", busy, 0);
    rst = 1'b0;
    step(2);

    // Normal run, react sampled on the sixth edge after lights-out
    run_to_timing("norm", 1, snap);
    step(5);
    react = 1'b1;
    step(1);
    react = 1'b0;
    check_eq("norm_valid", valid, 1);
    check_eq("norm_time", time_ms, 5);
    check_eq("norm_busy", busy, 0);
    step(1);
    check_eq("norm_valid_drop", valid, 0);
    check_eq("norm_time_hold", time_ms, 5);

    // Jump start during the build-up
    pulse_trigger();
    wait_lights("js_l1", 4'b0001, 40, snap);
    wait_lights("js_l2", 4'b0011, 40, snap);
    react = 1'b1;
    step(1);
    react = 1'b0;
    check_eq("js_lights", lights, 0);
    check_eq("js_jump", jump_start, 1);
    check_eq("js_busy", busy, 0);
    check_eq("js_time", time_ms, 5);
    seen = 1'b0;
    repeat (10) begin
      step(1);
      seen |= valid;
    end
    check_eq("js_no_valid", seen, 0);
    check_eq("js_jump_held", jump_start, 1);
    pulse_trigger();
    check_eq("js_jump_clr", jump_start, 0);
    check_eq("js_busy_go", busy, 1);

    // React on the final hold tick is still a jump start
    climb("bnd", 1, snap);
    step(3 + snap - 1);
    check_eq("bnd_still_on", lights, 4'b1111);
    react = 1'b1;
    step(1);
    react = 1'b0;
    check_eq("bnd_lights", lights, 0);
    check_eq("bnd_jump", jump_start, 1);
    check_eq("bnd_busy", busy, 0);
    check_eq("bnd_valid", valid, 0);
    check_eq("bnd_time", time_ms, 5);

    // Trigger while timing must not restart the sequence
    run_to_timing("tig", 1, snap);
    step(2);
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
    check_eq("tig_busy", busy, 1);
    check_eq("tig_lights", lights, 0);
    step(2);
    react = 1'b1;
    step(1);
    react = 1'b0;
    check_eq("tig_valid", valid, 1);
    check_eq("tig_time", time_ms, 5);

    // Saturation
    run_to_timing("sat", 1, snap);
    step(300);
    react = 1'b1;
    step(1);
    react = 1'b0;
    check_eq("sat_valid", valid, 1);
    check_eq("sat_time", time_ms, 255);

    // Tick every fourth cycle
    gate_mode = 1'b1;
    step(8);
    run_to_timing("gate", 4, snap);
    step(13);
    react = 1'b1;
    step(1);
    react = 1'b0;
    check_eq("gate_valid", valid, 1);
    check_eq("gate_time", time_ms, 3);
    gate_mode = 1'b0;
    step(4);

    // Reset in the middle of the hold
    pulse_trigger();
    climb("rsth", 1, snap);
    step(2);
    rst = 1'b1;
    #1;
    check_eq("rsth_lights", lights, 0);
    check_eq("rsth_time", time_ms, 0);
    check_eq("rsth_valid", valid, 0);
    check_eq("rsth_jump", jump_start, 0);
    check_eq("rsth_busy", busy, 0);
    check_eq("rsth_lfsr", 32'(dut.w_snap), 1);
    step(2);
    rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      step(1);
      if (busy || valid || (lights != 4'b0000)) seen = 1'b1;
    end
    check_eq("rsth_quiet", seen, 0);
    pulse_trigger();
    check_eq("rsth_restart", busy, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
